// File: rtl/cordic_result_serializer_pkg.sv
// Shared constants, byte-count helper and FSM state type for the CORDIC result serializer.
package pkg_cordic_sincos;

  localparam logic [7:0] SER_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    SIN  = 2'd2,
    COS  = 2'd3
  } ser_state_t;

  function automatic int ser_nbytes(input int bits);
    return (bits + 32'sd7) / 32'sd8;
  endfunction

endpackage

// File: rtl/cordic_result_serializer_fifo.sv
// Synchronous FIFO of {sin,cos} result pairs; read data is the head entry (first-word fall-through).
module cordic_result_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cordic_result_serializer.sv
// Buffers CORDIC sin/cos pairs and serializes them MSB-first onto a valid/ready byte stream.
// Optional header byte per record when CORDIC_SER_SYNC_EN is defined.
module cordic_result_serializer
  import pkg_cordic_sincos::*;
#(
  parameter int BITS  = 16,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_done,
  input  logic [BITS-1:0] i_sin,
  input  logic [BITS-1:0] i_cos,
  output logic            o_pipeline_en,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_valid,
  input  logic            i_tx_ready,
  output logic            o_busy
);

  localparam int NB = ser_nbytes(BITS);
  localparam int EW = NB * 8;
  localparam int SW = 2 * EW;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

`ifdef CORDIC_SER_SYNC_EN
  localparam ser_state_t FIRST_STATE = SYNC;
`else
  localparam ser_state_t FIRST_STATE = SIN;
`endif

  ser_state_t        state_r;
  ser_state_t        state_nxt_s;
  logic [IW-1:0]     idx_r;
  logic [IW-1:0]     idx_nxt_s;
  logic [SW-1:0]     shift_r;
  logic [7:0]        tx_data_r;
  logic              tx_valid_r;
  logic              pop_s;
  logic              accept_s;
  logic              xfer_s;
  logic              last_idx_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [CW-1:0]     fifo_count_s;
  logic [2*BITS-1:0] fifo_rd_s;
  logic [EW-1:0]     sin_ext_s;
  logic [EW-1:0]     cos_ext_s;
  logic [7:0]        first_byte_s;

  assign o_pipeline_en = (fifo_count_s != CW'(DEPTH));
  assign accept_s      = i_done & o_pipeline_en;
  assign xfer_s        = tx_valid_r & i_tx_ready;
  assign last_idx_s    = (idx_r == IW'(NB - 1));
  assign o_tx_data     = tx_data_r;
  assign o_tx_valid    = tx_valid_r;
  assign o_busy        = ~fifo_empty_s | (state_r != IDLE);

  assign sin_ext_s = EW'($signed(fifo_rd_s[2*BITS-1:BITS]));
  assign cos_ext_s = EW'($signed(fifo_rd_s[BITS-1:0]));

`ifdef CORDIC_SER_SYNC_EN
  assign first_byte_s = SER_SYNC_BYTE;
`else
  assign first_byte_s = sin_ext_s[EW-1 -: 8];
`endif

  cordic_result_fifo #(
    .WIDTH (2 * BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (accept_s),
    .wr_data ({i_sin, i_cos}),
    .pop     (pop_s),
    .rd_data (fifo_rd_s),
    .count   (fifo_count_s),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s)
  );

  // FSM state and byte index register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      idx_r   <= {IW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Next state, byte index and FIFO pop; COS end pops directly so records run without a bubble.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = FIRST_STATE;
          idx_nxt_s   = {IW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SYNC: begin
        if (xfer_s) begin
          state_nxt_s = SIN;
          idx_nxt_s   = {IW{1'b0}};
        end else begin
          state_nxt_s = SYNC;
        end
      end
      SIN: begin
        if (xfer_s && last_idx_s) begin
          state_nxt_s = COS;
          idx_nxt_s   = {IW{1'b0}};
        end else if (xfer_s) begin
          idx_nxt_s = idx_r + IW'(1'b1);
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      COS: begin
        if (xfer_s && last_idx_s) begin
          idx_nxt_s = {IW{1'b0}};
          if (!fifo_empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = FIRST_STATE;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (xfer_s) begin
          idx_nxt_s = idx_r + IW'(1'b1);
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = {IW{1'b0}};
      end
    endcase
  end

  // Shift register and registered byte output; tx_data always mirrors the byte on offer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_r    <= {SW{1'b0}};
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else if (pop_s) begin
      shift_r    <= {sin_ext_s, cos_ext_s};
      tx_data_r  <= first_byte_s;
      tx_valid_r <= 1'b1;
    end else if (xfer_s) begin
      if (state_nxt_s == IDLE) begin
        tx_data_r  <= 8'h00;
        tx_valid_r <= 1'b0;
      end else if (state_r == SYNC) begin
        tx_data_r <= shift_r[SW-1 -: 8];
      end else begin
        shift_r   <= {shift_r[SW-9:0], 8'h00};
        tx_data_r <= shift_r[SW-9 -: 8];
      end
    end
  end

endmodule

// File: tb/tb_cordic_result_serializer.sv
// Directed bench for cordic_result_serializer (BITS=16/DEPTH=4 plus a BITS=12/DEPTH=2 instance).
module tb_cordic_result_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        done, ready, en, tx_valid, busy;
  logic [15:0] sin, cos;
  logic [7:0]  tx_data;
  logic        done12, ready12, en12, tx_valid12, busy12;
  logic [11:0] sin12, cos12;
  logic [7:0]  tx_data12;

  int checks   = 0;
  int failures = 0;
  logic [7:0] cap[$];
  logic [7:0] cap12[$];
  logic [7:0] exp[$];
  logic [7:0] exp12[$];

  always #5 clk = ~clk;

  cordic_result_serializer #(.BITS(16), .DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_done(done), .i_sin(sin), .i_cos(cos),
    .o_pipeline_en(en), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .i_tx_ready(ready), .o_busy(busy)
  );

  cordic_result_serializer #(.BITS(12), .DEPTH(2)) dut12 (
    .i_clk(clk), .i_rst_n(rst_n), .i_done(done12), .i_sin(sin12), .i_cos(cos12),
    .o_pipeline_en(en12), .o_tx_data(tx_data12), .o_tx_valid(tx_valid12),
    .i_tx_ready(ready12), .o_busy(busy12)
  );

  always @(posedge clk) begin
    if (rst_n && tx_valid && ready) cap.push_back(tx_data);
    if (rst_n && tx_valid12 && ready12) cap12.push_back(tx_data12);
  end

  function automatic void add_rec(input logic [15:0] s, input logic [15:0] c);
`ifdef CORDIC_SER_SYNC_EN
    exp.push_back(8'hA5);
`endif
    exp.push_back(s[15:8]);
    exp.push_back(s[7:0]);
    exp.push_back(c[15:8]);
    exp.push_back(c[7:0]);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; done = 1'b0; ready = 1'b0; sin = 16'h0000; cos = 16'h0000;
    done12 = 1'b0; ready12 = 1'b0; sin12 = 12'h000; cos12 = 12'h000;
    repeat (3) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (en !== 1'b1) begin failures++; $display("FAIL reset_en got=%b exp=1", en); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || en !== 1'b1) begin
      failures++; $display("FAIL post_reset_idle got=v%b b%b e%b exp=v0 b0 e1", tx_valid, busy, en);
    end
  endtask

  task automatic test_single();
    exp.delete(); cap.delete();
    add_rec(16'h2D41, 16'h2D41);
    ready = 1'b1; done = 1'b1; sin = 16'h2D41; cos = 16'h2D41;
    @(negedge clk);
    done = 1'b0;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL single_n1 got=v%b b%b exp=v0 b1", tx_valid, busy);
    end
    @(negedge clk);
    for (int k = 0; k < exp.size(); k++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp[k]) begin
        failures++; $display("FAIL single_byte%0d got=v%b %h exp=v1 %h", k, tx_valid, tx_data, exp[k]);
      end
      @(negedge clk);
    end
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || en !== 1'b1) begin
      failures++; $display("FAIL single_end got=v%b b%b e%b exp=v0 b0 e1", tx_valid, busy, en);
    end
  endtask

  task automatic test_back_to_back();
    exp.delete(); cap.delete();
    add_rec(16'h1234, 16'h5678);
    add_rec(16'h9ABC, 16'hDEF0);
    ready = 1'b1; done = 1'b1; sin = 16'h1234; cos = 16'h5678;
    @(negedge clk);
    sin = 16'h9ABC; cos = 16'hDEF0;
    @(negedge clk);
    done = 1'b0;
    for (int k = 0; k < exp.size(); k++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp[k]) begin
        failures++; $display("FAIL b2b_byte%0d got=v%b %h exp=v1 %h", k, tx_valid, tx_data, exp[k]);
      end
      @(negedge clk);
    end
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_end got=v%b b%b exp=v0 b0", tx_valid, busy);
    end
  endtask

  task automatic test_ready_toggle();
    logic       prev_stall;
    logic [7:0] prev_data;
    exp.delete(); cap.delete();
    add_rec(16'h8001, 16'h7FFE);
    ready = 1'b1; done = 1'b1; sin = 16'h8001; cos = 16'h7FFE;
    @(negedge clk);
    done = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
    for (int i = 0; i < 60; i++) begin
      if (prev_stall) begin
        checks++; if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          failures++; $display("FAIL toggle_hold got=v%b %h exp=v1 %h", tx_valid, tx_data, prev_data);
        end
      end
      if (cap.size() == exp.size() && !tx_valid) break;
      ready = ~ready;
      prev_stall = tx_valid & ~ready;
      prev_data  = tx_data;
      @(negedge clk);
    end
    ready = 1'b1;
    checks++; if (cap.size() != exp.size()) begin
      failures++; $display("FAIL toggle_count got=%0d exp=%0d", cap.size(), exp.size());
    end else begin
      for (int k = 0; k < exp.size(); k++) begin
        checks++; if (cap[k] !== exp[k]) begin
          failures++; $display("FAIL toggle_byte%0d got=%h exp=%h", k, cap[k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_fill_stall();
    int   vi;
    logic acc_pending;
    exp.delete(); cap.delete();
    for (int i = 0; i < 6; i++) add_rec({8'h10 + 8'(i), 8'h20 + 8'(i)}, {8'h30 + 8'(i), 8'h40 + 8'(i)});
    ready = 1'b0; vi = 0; done = 1'b1;
    sin = {8'h10, 8'h20}; cos = {8'h30, 8'h40};
    acc_pending = done & en;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (acc_pending) begin
        vi++;
        if (vi < 6) begin sin = {8'h10 + 8'(vi), 8'h20 + 8'(vi)}; cos = {8'h30 + 8'(vi), 8'h40 + 8'(vi)}; end
        else done = 1'b0;
      end
      acc_pending = done & en;
    end
    checks++; if (vi !== 5) begin failures++; $display("FAIL fill_accepts got=%0d exp=5", vi); end
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL fill_en got=%b exp=0", en); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== exp[0]) begin
      failures++; $display("FAIL fill_hold got=v%b %h exp=v1 %h", tx_valid, tx_data, exp[0]);
    end
    ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (acc_pending) begin
        vi++;
        if (vi < 6) begin sin = {8'h10 + 8'(vi), 8'h20 + 8'(vi)}; cos = {8'h30 + 8'(vi), 8'h40 + 8'(vi)}; end
        else done = 1'b0;
      end
      acc_pending = done & en;
      if (vi == 6 && !busy) break;
    end
    repeat (3) @(negedge clk);
    checks++; if (vi !== 6 || busy !== 1'b0 || en !== 1'b1) begin
      failures++; $display("FAIL fill_drain got=acc%0d b%b e%b exp=acc6 b0 e1", vi, busy, en);
    end
    checks++; if (cap.size() != exp.size()) begin
      failures++; $display("FAIL fill_count got=%0d exp=%0d", cap.size(), exp.size());
    end else begin
      for (int k = 0; k < exp.size(); k++) begin
        checks++; if (cap[k] !== exp[k]) begin
          failures++; $display("FAIL fill_byte%0d got=%h exp=%h", k, cap[k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp.delete(); cap.delete();
    ready = 1'b1; done = 1'b1; sin = 16'h1357; cos = 16'h2468;
    @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);
`ifdef CORDIC_SER_SYNC_EN
    @(negedge clk);
`endif
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h57) begin
      failures++; $display("FAIL rstmid_2nd got=v%b %h exp=v1 57", tx_valid, tx_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      failures++; $display("FAIL rstmid_async got=v%b %h exp=v0 00", tx_valid, tx_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || en !== 1'b1 || tx_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_after got=b%b e%b v%b exp=b0 e1 v0", busy, en, tx_valid);
    end
    cap.delete();
    add_rec(16'hFEDC, 16'h0123);
    done = 1'b1; sin = 16'hFEDC; cos = 16'h0123;
    @(negedge clk);
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (cap.size() >= exp.size() && !busy) break;
      @(negedge clk);
    end
    checks++; if (cap.size() != exp.size()) begin
      failures++; $display("FAIL rstmid_count got=%0d exp=%0d", cap.size(), exp.size());
    end else begin
      for (int k = 0; k < exp.size(); k++) begin
        checks++; if (cap[k] !== exp[k]) begin
          failures++; $display("FAIL rstmid_byte%0d got=%h exp=%h", k, cap[k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_bits12();
    exp12.delete(); cap12.delete();
`ifdef CORDIC_SER_SYNC_EN
    exp12.push_back(8'hA5);
`endif
    exp12.push_back(8'hFC); exp12.push_back(8'h00);
    exp12.push_back(8'h04); exp12.push_back(8'h00);
    ready12 = 1'b1; done12 = 1'b1; sin12 = 12'hC00; cos12 = 12'h400;
    @(negedge clk);
    done12 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (cap12.size() >= exp12.size() && !busy12) break;
      @(negedge clk);
    end
    checks++; if (cap12.size() != exp12.size()) begin
      failures++; $display("FAIL b12_count got=%0d exp=%0d", cap12.size(), exp12.size());
    end else begin
      for (int k = 0; k < exp12.size(); k++) begin
        checks++; if (cap12[k] !== exp12[k]) begin
          failures++; $display("FAIL b12_byte%0d got=%h exp=%h", k, cap12[k], exp12[k]);
        end
      end
    end
    checks++; if (en12 !== 1'b1 || tx_valid12 !== 1'b0) begin
      failures++; $display("FAIL b12_end got=e%b v%b exp=e1 v0", en12, tx_valid12);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ready_toggle();
    test_fill_stall();
    test_reset_mid();
    test_bits12();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
